conv_sobel_window: RTL
======================

Name: conv_sobel_window

Overview:
- Consumes the three aligned row streams produced by the convolution row feeder. Each cycle it may take one pixel column: top, middle and bottom row.
- Holds a 3x3 sliding window and computes a Sobel gradient (Ix or Iy) for each complete window.
- Sends the signed result downstream over a val/rdy interface to the LK gradient-product stage.
- Sits directly downstream of the row feeder, one instance per gradient direction.

Parameters:
- data_width, 32, unsigned pixel width of each input row stream.
- out_width, data_width+3, signed two's-complement result width. It must be at least data_width+3.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- win_dim  input  4  window dimension; valid outputs per row = win_dim (row length win_dim+2 columns)
- kernel_sel  input  1  0 = Sobel X, 1 = Sobel Y
- in_val  input  3  per-row valid; index 0 = top/oldest row, 2 = bottom/newest
- in_rdy  output  3  per-row ready; all three bits always equal
- in_msg  input  3 x data_width  per-row pixel
- in_new_row  input  1  qualifies the column accepted this cycle as the first column of a row
- out_val  output  1  result valid
- out_rdy  input  1  downstream ready
- out_msg  output  out_width  signed gradient
- out_last  output  1  marks the final result of a row

Behaviour:
- Reset values: out_val=0, out_msg=0, out_last=0, column state EMPTY, output column counter 0, latched kernel 0.
- in_rdy = !out_val || out_rdy, replicated on all 3 bits.
- Column accept: all three in_val high AND in_rdy high. Partial in_val is ignored and nothing is consumed.
- Window: three column registers c0 (oldest), c1, c2 (newest), each holding top/mid/bot pixels. On accept, the window shifts: c0<=c1, c1<=c2, c2<=in_msg.
- Fill FSM:
  - States EMPTY -> ONE -> TWO -> FULL, advancing on each accept. FULL stays FULL on accept.
  - An accept with in_new_row=1 forces the next state to ONE from any state. Any partial window is discarded, and the output column counter clears to 0.
  - An accept that lands in FULL (i.e. from TWO or FULL without in_new_row) produces a result.
- Kernel: kernel_sel is latched on every accept with in_new_row=1, and on the first accept after reset. It is constant for the rest of the row.
- Arithmetic, with pixels zero-extended to out_width before the add:
  - Gx = (t2 + 2*m2 + b2) - (t0 + 2*m0 + b0)
  - Gy = (b0 + 2*b1 + b2) - (t0 + 2*t1 + t2)
  - t/m/b are the top/mid/bot pixels and the digit is the column index. No overflow is possible at the minimum out_width.
- Latency: a result is computed from the post-shift window. out_val rises the cycle after the completing accept, and out_msg is registered.
- Output hold: out_msg and out_last stay stable while out_val && !out_rdy. out_val clears on out_rdy unless a new result loads in the same cycle; the bypass case of accept and out_rdy together keeps out_val=1 with new data.
- out_last:
  - Asserts with a result when the output column counter equals win_dim-1; the counter then wraps to 0, otherwise it increments per result.
  - win_dim=0: out_last never asserts.
  - More columns than win_dim+2 without in_new_row: the window keeps sliding and results keep being produced, with the counter wrapping.
- Reset mid-operation: the window contents become don't-care, and the state returns to EMPTY. Any pending output is dropped.

Optional Feature:
- Macro CONV_SOBEL_WINDOW_STATS_EN.
- Defined: adds output port out_count (output, 16 bits), a count of handshaken results (out_val && out_rdy) since reset. It wraps at 65535->0 and resets to 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Gx, row with win_dim=1, kernel_sel=0: columns (t,m,b) = (1,4,7), (2,5,8), (3,6,9), new_row on the first, out_rdy=1 -> exactly one result, out_msg=8, out_last=1, one cycle after the third accept.
- Gy: same stimulus with kernel_sel=1 -> out_msg=24, out_last=1.
- Negative result and wrap: win_dim=2, four columns (9,9,9), (0,0,0), (0,0,0), (0,0,0), kernel X -> results -36, then 0 with out_last=1. A following new_row column gives no output until 3 columns are accepted.
- Backpressure: hold out_rdy=0 with a result pending -> in_rdy=0, out_msg stable, further columns not consumed. Raising out_rdy resumes with no loss or duplication.
- Partial valid and mid-row restart: in_val=3'b011 for 3 cycles -> no accept. A new_row column after 2 accepted columns -> no result until 2 further columns.
- Reset mid-row: after TWO, assert reset one cycle -> out_val=0; the next 2 accepts produce no output and the 3rd does. With STATS_EN, out_count=0 after reset and increments per handshake.

Source files
------------

// File: rtl/conv_sobel_window.sv
`default_nettype none
// ============================================================================
// Module   : conv_sobel_window
// Purpose  : 3x3 sliding window over three aligned row streams. Produces one
//            signed Sobel gradient (X or Y) per complete window over a
//            val/rdy output with a per-row last marker.
// Options  : `define CONV_SOBEL_WINDOW_STATS_EN adds out_count, a 16-bit
//            wrapping count of handshaken results since reset.
// Revision : 1.0 - initial release
// ============================================================================
module conv_sobel_window #(
  parameter int DATA_WIDTH = 32,
  // Must be at least DATA_WIDTH+3 so the gradient cannot overflow.
  parameter int OUT_WIDTH  = DATA_WIDTH + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              win_dim,
  input  logic                    kernel_sel,
  input  logic [2:0]              in_val,
  output logic [2:0]              in_rdy,
  input  logic [3*DATA_WIDTH-1:0] in_msg,
  input  logic                    in_new_row,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [OUT_WIDTH-1:0]    out_msg,
  output logic                    out_last
`ifdef CONV_SOBEL_WINDOW_STATS_EN
  ,
  output logic [15:0]             out_count
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic                    w_rdy;
  logic                    w_accept;
  logic                    w_produce;
  logic                    w_last;

  // The oldest column is only needed at the accept that shifts it out, so
  // just the two newer columns are stored; the post-shift window is
  // {r_c1, r_c2, in_msg} (oldest to newest).
  logic [3*DATA_WIDTH-1:0] r_c1;
  logic [3*DATA_WIDTH-1:0] r_c2;

  logic                    r_kernel;
  logic                    r_first;
  logic [3:0]              r_col_cnt;
  logic                    r_out_val;
  logic [OUT_WIDTH-1:0]    r_out_msg;
  logic                    r_out_last;

  logic [OUT_WIDTH-1:0]    w_t0, w_m0, w_b0;
  logic [OUT_WIDTH-1:0]    w_t1, w_b1;
  logic [OUT_WIDTH-1:0]    w_t2, w_m2, w_b2;
  logic [OUT_WIDTH-1:0]    w_gx;
  logic [OUT_WIDTH-1:0]    w_gy;

  function automatic logic [OUT_WIDTH-1:0] f_ext(input logic [DATA_WIDTH-1:0] px);
    return {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, px};
  endfunction

  assign w_rdy    = !r_out_val || out_rdy;
  assign in_rdy   = {3{w_rdy}};
  assign w_accept = (&in_val) && w_rdy;

  assign out_val  = r_out_val;
  assign out_msg  = r_out_msg;
  assign out_last = r_out_last;

  // Zero-extended pixels of the post-shift window (column 0 = oldest).
  assign w_t0 = f_ext(r_c1[0*DATA_WIDTH +: DATA_WIDTH]);
  assign w_m0 = f_ext(r_c1[1*DATA_WIDTH +: DATA_WIDTH]);
  assign w_b0 = f_ext(r_c1[2*DATA_WIDTH +: DATA_WIDTH]);
  assign w_t1 = f_ext(r_c2[0*DATA_WIDTH +: DATA_WIDTH]);
  assign w_b1 = f_ext(r_c2[2*DATA_WIDTH +: DATA_WIDTH]);
  assign w_t2 = f_ext(in_msg[0*DATA_WIDTH +: DATA_WIDTH]);
  assign w_m2 = f_ext(in_msg[1*DATA_WIDTH +: DATA_WIDTH]);
  assign w_b2 = f_ext(in_msg[2*DATA_WIDTH +: DATA_WIDTH]);

  // Two's-complement wraparound of the subtraction yields the signed result.
  assign w_gx = (w_t2 + (w_m2 << 1) + w_b2) - (w_t0 + (w_m0 << 1) + w_b0);
  assign w_gy = (w_b0 + (w_b1 << 1) + w_b2) - (w_t0 + (w_t1 << 1) + w_t2);

  assign w_last = (win_dim != 4'd0) && (r_col_cnt == (win_dim - 4'd1));

  // Fill-state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fill-state advance: one step per accepted column, new_row restarts at ONE.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (in_new_row) begin
        w_state_nxt = S_ONE;
      end else begin
        case (r_state)
          S_EMPTY: w_state_nxt = S_ONE;
          S_ONE:   w_state_nxt = S_TWO;
          default: w_state_nxt = S_FULL;
        endcase
      end
    end
  end

  // A result is due when an in-row accept completes the window.
  always_comb begin
    w_produce = 1'b0;
    if (w_accept && !in_new_row && (r_state == S_TWO || r_state == S_FULL)) begin
      w_produce = 1'b1;
    end
  end

  // Window shift on every accepted column; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_c1 <= r_c2;
      r_c2 <= in_msg;
    end
  end

  // Kernel selection is captured at row start and on the first accept after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kernel <= 1'b0;
      r_first  <= 1'b1;
    end else if (w_accept) begin
      r_first <= 1'b0;
      if (in_new_row || r_first) begin
        r_kernel <= kernel_sel;
      end
    end
  end

  // Output column counter: clears at row start, wraps after the last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_cnt <= 4'd0;
    end else if (w_accept && in_new_row) begin
      r_col_cnt <= 4'd0;
    end else if (w_produce) begin
      r_col_cnt <= w_last ? 4'd0 : r_col_cnt + 4'd1;
    end
  end

  // Output register: loads a new result (also while handshaking the old one),
  // otherwise drains on out_rdy and holds under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_val  <= 1'b0;
      r_out_msg  <= '0;
      r_out_last <= 1'b0;
    end else if (w_produce) begin
      r_out_val  <= 1'b1;
      r_out_msg  <= r_kernel ? w_gy : w_gx;
      r_out_last <= w_last;
    end else if (out_rdy) begin
      r_out_val  <= 1'b0;
    end
  end

`ifdef CONV_SOBEL_WINDOW_STATS_EN
  logic [15:0] r_out_count;

  // Count of handshaken results, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_count <= 16'd0;
    end else if (r_out_val && out_rdy) begin
      r_out_count <= r_out_count + 16'd1;
    end
  end

  assign out_count = r_out_count;
`endif

endmodule
`default_nettype wire
